// File: rtl/pe_result_writeback_if.sv
// Result-stream and memory write-bus interfaces for the PE writeback stage.
// master drives the payload/request; slave returns ready/ack.

interface pe_result_if #(
    parameter int unsigned RESULT_WIDTH = 512
);
    logic                    valid_in;
    logic                    ready_out;
    logic [RESULT_WIDTH-1:0] result_packed_i;

    modport master (output valid_in, output result_packed_i, input ready_out);
    modport slave  (input valid_in, input result_packed_i, output ready_out);
endinterface

interface pe_mem_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_WIDTH  = 256
);
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [MEM_WIDTH-1:0]  mem_data_o;
    logic                  mem_ack_i;

    modport master (output mem_req_o, output mem_addr_o, output mem_data_o, input mem_ack_i);
    modport slave  (input mem_req_o, input mem_addr_o, input mem_data_o, output mem_ack_i);
endinterface

// File: rtl/pe_result_writeback.sv
// Buffers packed PE result vectors and streams them out as MEM_WIDTH write beats
// to an auto-incrementing byte address.

module pe_result_writeback #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned VECTOR_WIDTH = 16,
    parameter int unsigned MEM_WIDTH    = 256,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    pe_result_if.slave                    res,
    pe_mem_if.master                      mem,
    input  logic [ADDR_WIDTH-1:0]         wb_base_addr_i,
    input  logic                          wb_load_i,
    output logic                          wb_done_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o
);
    localparam int unsigned RES_W      = DATA_WIDTH * VECTOR_WIDTH;
    localparam int unsigned BEATS      = RES_W / MEM_WIDTH;
    localparam int unsigned BEAT_BYTES = MEM_WIDTH / 8;
    localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [RES_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
    logic [CNT_W-1:0]      count_q, count_n;
    logic [0:0]            state_q, state_n;
    logic [BEAT_W-1:0]     beat_q, beat_n;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_n;
    logic [MEM_WIDTH-1:0]  data_q, data_n;
    logic                  req_q, req_n;
    logic                  ready_q, ready_n;
    logic                  done_q, done_n;
    logic                  busy_q, busy_n;
    logic                  push, fire, pop;
    logic [RES_W-1:0]      head, next_head;

    function automatic logic [MEM_WIDTH-1:0] beat_slice(input logic [RES_W-1:0] v,
                                                        input logic [BEAT_W-1:0] b);
        return MEM_WIDTH'(v >> (32'(b) * MEM_WIDTH));
    endfunction

    assign push = res.valid_in && ready_q;
    assign fire = req_q && mem.mem_ack_i;
    assign pop  = fire && (beat_q == BEAT_W'(BEATS - 1));
    assign head = fifo_mem[rd_ptr_q];
    // With a single entry left, the successor may be the one being pushed this cycle.
    assign next_head = (count_q == CNT_W'(1)) ? res.result_packed_i
                                              : fifo_mem[rd_ptr_q + PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= res.result_packed_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            wptr_q   <= '0;
            data_q   <= '0;
            req_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_n;
            beat_q   <= beat_n;
            wptr_q   <= wptr_n;
            data_q   <= data_n;
            req_q    <= req_n;
            ready_q  <= ready_n;
            done_q   <= done_n;
            busy_q   <= busy_n;
            count_q  <= count_n;
            wr_ptr_q <= wr_ptr_n;
            rd_ptr_q <= rd_ptr_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        beat_n   = beat_q;
        wptr_n   = wptr_q;
        data_n   = data_q;
        req_n    = req_q;
        wr_ptr_n = wr_ptr_q;
        rd_ptr_n = rd_ptr_q;
        count_n  = count_q;
        done_n   = pop;

        if (push) begin
            wr_ptr_n = wr_ptr_q + PTR_W'(1);
            count_n  = count_n + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_n = rd_ptr_q + PTR_W'(1);
            count_n  = count_n - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                req_n = 1'b0;
                if (wb_load_i && count_q == '0) wptr_n = wb_base_addr_i;
                if (count_q != '0) state_n = SEND;
            end
            SEND: begin
                // First SEND cycle loads the beat registers; afterwards they move only on ack.
                if (!req_q) begin
                    req_n  = 1'b1;
                    data_n = beat_slice(head, beat_q);
                end else if (fire) begin
                    wptr_n = wptr_q + ADDR_WIDTH'(BEAT_BYTES);
                    if (!pop) begin
                        beat_n = beat_q + BEAT_W'(1);
                        data_n = beat_slice(head, beat_n);
                    end else begin
                        beat_n = '0;
                        if (count_n != '0) begin
                            data_n = beat_slice(next_head, '0);
                        end else begin
                            req_n   = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        ready_n = (count_n != CNT_W'(FIFO_DEPTH));
        busy_n  = (state_n == SEND) || (count_n != '0);
    end

    assign res.ready_out  = ready_q;
    assign mem.mem_req_o  = req_q;
    assign mem.mem_addr_o = wptr_q;
    assign mem.mem_data_o = data_q;
    assign wb_done_o      = done_q;
    assign fifo_count_o   = count_q;
    assign busy_o         = busy_q;
endmodule

// File: tb/tb_pe_result_writeback.sv
// Bench for pe_result_writeback: table-driven single-result transfers plus
// stall, backpressure, reset and reload sequences, checked by a beat scoreboard.

module tb_pe_result_writeback;
    localparam int unsigned DW    = 32;
    localparam int unsigned VW    = 16;
    localparam int unsigned MW    = 256;
    localparam int unsigned FD    = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned RW    = DW * VW;
    localparam int unsigned BEATS = RW / MW;

    typedef struct {
        logic [AW-1:0] a;
        logic [MW-1:0] d;
    } beat_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [DW-1:0] seed;
        logic [AW-1:0] a1;
        logic [AW-1:0] end_ptr;
        logic [DW-1:0] b1_lane0;
    } vec_t;

    logic                    clk;
    logic                    rst;
    logic [AW-1:0]           base;
    logic                    load;
    logic                    done;
    logic [$clog2(FD):0]     cnt;
    logic                    busy;

    pe_result_if #(.RESULT_WIDTH(RW))              res ();
    pe_mem_if    #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW)) mem ();

    pe_result_writeback #(
        .DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .MEM_WIDTH(MW),
        .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .res            (res),
        .mem            (mem),
        .wb_base_addr_i (base),
        .wb_load_i      (load),
        .wb_done_o      (done),
        .fifo_count_o   (cnt),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t         sb [$];
    beat_t         mon_e;
    int unsigned   tests, fails, done_cnt, beat_cnt;
    logic [AW-1:0] exp_ptr;
    logic [AW-1:0] last_addr;
    logic [MW-1:0] last_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Beats are accepted at the posedge following a negedge with req && ack.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem.mem_req_o && mem.mem_ack_i) begin
                beat_cnt++;
                last_addr = mem.mem_addr_o;
                last_data = mem.mem_data_o;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got addr %0h, none expected", mem.mem_addr_o);
                end else begin
                    mon_e = sb.pop_front();
                    if (mem.mem_addr_o !== mon_e.a || mem.mem_data_o !== mon_e.d) begin
                        fails++;
                        $display("FAIL beat: got addr %0h data %h expected addr %0h data %h",
                                 mem.mem_addr_o, mem.mem_data_o, mon_e.a, mon_e.d);
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    function automatic logic [RW-1:0] make_vec(input logic [DW-1:0] seed);
        logic [RW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(VW); i++) v[i*DW +: DW] = seed + DW'(i);
        return v;
    endfunction

    task automatic sb_push(input logic [RW-1:0] v);
        for (int k = 0; k < int'(BEATS); k++) begin
            sb.push_back('{a: exp_ptr, d: v[k*MW +: MW]});
            exp_ptr = exp_ptr + AW'(MW / 8);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic push(input logic [RW-1:0] v, input logic ld, input logic [AW-1:0] b);
        res.valid_in        = 1'b1;
        res.result_packed_i = v;
        load                = ld;
        if (ld) base = b;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (res.ready_out) begin
                if (ld) exp_ptr = b;
                sb_push(v);
                @(posedge clk); #1;
                res.valid_in = 1'b0;
                load         = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        tests++;
        fails++;
        $display("FAIL push_timeout: got ready_out 0 expected 1");
        res.valid_in = 1'b0;
        load         = 1'b0;
    endtask

    task automatic load_idle(input logic [AW-1:0] b);
        load = 1'b1;
        base = b;
        @(posedge clk); #1;
        load    = 1'b0;
        exp_ptr = b;
    endtask

    task automatic wait_done(input int unsigned target, input int unsigned budget, input string name);
        int unsigned c;
        c = 0;
        while (done_cnt < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk); #1;
        check(name, 64'(done_cnt), 64'(target));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    vec_t          tbl [4];
    int unsigned   bc0, dc0;
    logic [AW-1:0] ea;
    logic [RW-1:0] v;

    initial begin
        tests = 0; fails = 0; done_cnt = 0; beat_cnt = 0;
        exp_ptr = '0; last_addr = '0; last_data = '0;
        tbl[0] = '{32'h0000_1000, 32'h1,   32'h0000_1020, 32'h0000_1040, 32'h9};
        tbl[1] = '{32'hFFFF_FFE0, 32'hA0,  32'h0000_0000, 32'h0000_0020, 32'hA8};
        tbl[2] = '{32'h0000_0000, 32'h100, 32'h0000_0020, 32'h0000_0040, 32'h108};
        tbl[3] = '{32'h7FFF_FFF0, 32'h77,  32'h8000_0010, 32'h8000_0030, 32'h7F};

        rst = 1'b1; load = 1'b0; base = '0;
        res.valid_in = 1'b0; res.result_packed_i = '0; mem.mem_ack_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_ready", 64'(res.ready_out), 64'd1);
        check("rst_req",   64'(mem.mem_req_o), 64'd0);
        check("rst_addr",  64'(mem.mem_addr_o), 64'd0);
        check("rst_data_zero", 64'(mem.mem_data_o == '0), 64'd1);
        check("rst_done",  64'(done), 64'd0);
        check("rst_count", 64'(cnt), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        rst = 1'b0;
        cycles(1);

        // Single results with ack tied high: latency, addressing, lane order, wrap.
        mem.mem_ack_i = 1'b1;
        for (int t = 0; t < 4; t++) begin
            load_idle(tbl[t].base);
            bc0 = beat_cnt;
            dc0 = done_cnt;
            push(make_vec(tbl[t].seed), 1'b0, '0);
            check("lat_req_p0", 64'(mem.mem_req_o), 64'd0);
            cycles(1);
            check("lat_req_p1", 64'(mem.mem_req_o), 64'd0);
            cycles(1);
            check("lat_req_p2", 64'(mem.mem_req_o), 64'd1);
            check("beat0_addr", 64'(mem.mem_addr_o), 64'(tbl[t].base));
            check("beat0_lane0", 64'(mem.mem_data_o[DW-1:0]), 64'(tbl[t].seed));
            wait_done(dc0 + 1, 20, "tbl_done");
            check("tbl_beats", 64'(beat_cnt - bc0), 64'd2);
            check("tbl_beat1_addr", 64'(last_addr), 64'(tbl[t].a1));
            check("tbl_beat1_lane0", 64'(last_data[DW-1:0]), 64'(tbl[t].b1_lane0));
            check("tbl_busy_low", 64'(busy), 64'd0);
            check("tbl_end_ptr", 64'(mem.mem_addr_o), 64'(tbl[t].end_ptr));
        end

        // Ack held low for 5 cycles: request, address and data stay put.
        mem.mem_ack_i = 1'b0;
        bc0 = beat_cnt;
        dc0 = done_cnt;
        ea  = exp_ptr;
        v   = make_vec(32'h200);
        push(v, 1'b0, '0);
        cycles(2);
        for (int i = 0; i < 6; i++) begin
            check("stall_req",  64'(mem.mem_req_o), 64'd1);
            check("stall_addr", 64'(mem.mem_addr_o), 64'(ea));
            check("stall_data", 64'(mem.mem_data_o == v[MW-1:0]), 64'd1);
            if (i == 5) mem.mem_ack_i = 1'b1;
            else cycles(1);
        end
        wait_done(dc0 + 1, 20, "stall_done");
        check("stall_beats", 64'(beat_cnt - bc0), 64'd2);

        // Five results against a stalled memory: four buffered, fifth backpressured.
        mem.mem_ack_i = 1'b0;
        bc0 = beat_cnt;
        dc0 = done_cnt;
        for (int k = 0; k < 4; k++) push(make_vec(32'h300 + 32'(k) * 32'h10), 1'b0, '0);
        check("full_count", 64'(cnt), 64'd4);
        check("full_ready", 64'(res.ready_out), 64'd0);
        res.valid_in        = 1'b1;
        res.result_packed_i = make_vec(32'h340);
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            check("full_hold_ready", 64'(res.ready_out), 64'd0);
        end
        mem.mem_ack_i = 1'b1;
        push(make_vec(32'h340), 1'b0, '0);
        wait_done(dc0 + 5, 100, "full_done");
        check("full_beats", 64'(beat_cnt - bc0), 64'd10);
        check("full_sb_empty", 64'(sb.size()), 64'd0);

        // Reset mid-beat with three results queued.
        mem.mem_ack_i = 1'b0;
        for (int k = 0; k < 3; k++) push(make_vec(32'h400 + 32'(k) * 32'h10), 1'b0, '0);
        cycles(2);
        check("pre_rst_req", 64'(mem.mem_req_o), 64'd1);
        dc0 = done_cnt;
        rst = 1'b1;
        #1;
        check("rst_mid_req",   64'(mem.mem_req_o), 64'd0);
        check("rst_mid_count", 64'(cnt), 64'd0);
        check("rst_mid_ready", 64'(res.ready_out), 64'd1);
        check("rst_mid_busy",  64'(busy), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cycles(2);
        check("rst_no_done", 64'(done_cnt), 64'(dc0));
        mem.mem_ack_i = 1'b1;
        load_idle(32'h0000_2000);
        dc0 = done_cnt;
        push(make_vec(32'h500), 1'b0, '0);
        wait_done(dc0 + 1, 20, "post_rst_done");
        check("post_rst_ptr", 64'(mem.mem_addr_o), 64'h2040);

        // Load during SEND is ignored; load with a push while idle applies.
        mem.mem_ack_i = 1'b0;
        load_idle(32'h0000_3000);
        dc0 = done_cnt;
        push(make_vec(32'h600), 1'b0, '0);
        push(make_vec(32'h610), 1'b0, '0);
        cycles(2);
        load = 1'b1;
        base = 32'hDEAD_0000;
        cycles(1);
        load = 1'b0;
        mem.mem_ack_i = 1'b1;
        wait_done(dc0 + 2, 40, "ld_send_done");
        check("ld_send_ptr", 64'(mem.mem_addr_o), 64'h3080);
        dc0 = done_cnt;
        push(make_vec(32'h700), 1'b1, 32'h0000_5000);
        wait_done(dc0 + 1, 20, "ld_push_done");
        check("ld_push_ptr", 64'(mem.mem_addr_o), 64'h5040);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
